// File: rtl/snn_pkg.sv
// Shared types and default sizing for the spike-count classifier.
package snn_pkg;

  localparam int NUM_OUT_DEF = 2;
  localparam int CNT_W_DEF   = 8;
  // Width of one neuron's slice in the flattened counts bus.
  localparam int SLICE_W     = CNT_W_DEF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COUNT,
    ST_DECIDE,
    ST_HOLD
  } state_e;

endpackage

// File: rtl/spike_counter.sv
// Per-neuron saturating spike counter with synchronous clear.
module spike_counter
  import snn_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] count_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign count_o = cnt_q;

endmodule

// File: rtl/spike_count_classifier.sv
// Counts output-layer spikes over a window of timesteps and reports the
// winning neuron (argmax, lowest index on ties) through a valid/ready handshake.
//
//   state  | meaning
//   IDLE   | waiting for start
//   COUNT  | accumulating spikes on each pulse until the window ends
//   DECIDE | one cycle: counters are final, argmax is evaluated
//   HOLD   | result presented until class_ready
module spike_count_classifier
  import snn_pkg::*;
#(
  parameter int NUM_OUT = NUM_OUT_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       pulse,
  input  logic [NUM_OUT-1:0]         spk_in,
  input  logic                       start,
  input  logic [CNT_W-1:0]           window_len,
  output logic                       busy,
  output logic                       class_valid,
  input  logic                       class_ready,
  output logic [$clog2(NUM_OUT)-1:0] class_id,
  output logic                       class_tie,
  output logic                       no_spike,
  output logic [NUM_OUT*CNT_W-1:0]   counts
);

  localparam int ID_W = $clog2(NUM_OUT);

  state_e                   state_q, state_d;
  logic [CNT_W-1:0]         len_q, len_d;
  logic [CNT_W-1:0]         ts_q, ts_d;
  logic                     valid_q, valid_d;
  logic [ID_W-1:0]          id_q, id_d;
  logic                     tie_q, tie_d;
  logic                     nospk_q, nospk_d;
  logic [NUM_OUT*CNT_W-1:0] counts_q, counts_d;

  logic                     cnt_clr, cnt_en;
  logic [CNT_W-1:0]         cnt [NUM_OUT];

  for (genvar g = 0; g < NUM_OUT; g++) begin : g_cnt
    spike_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk_i   (clk),
      .rst_i   (reset),
      .clr_i   (cnt_clr),
      .inc_i   (cnt_en & spk_in[g]),
      .count_o (cnt[g])
    );
  end

  logic [CNT_W-1:0]         max_v;
  logic [ID_W-1:0]          best_id;
  logic                     best_tie, all_zero;
  logic [NUM_OUT*CNT_W-1:0] cnt_flat;

  // Strict '>' keeps the lowest index on equal counts.
  always_comb begin
    max_v    = cnt[0];
    best_id  = '0;
    best_tie = 1'b0;
    cnt_flat = '0;
    for (int i = 0; i < NUM_OUT; i++) begin
      cnt_flat[i*CNT_W +: CNT_W] = cnt[i];
    end
    for (int i = 1; i < NUM_OUT; i++) begin
      if (cnt[i] > max_v) begin
        max_v    = cnt[i];
        best_id  = ID_W'(i);
        best_tie = 1'b0;
      end else if (cnt[i] == max_v) begin
        best_tie = 1'b1;
      end
    end
    all_zero = (max_v == '0);
    if (all_zero) best_tie = 1'b1;
  end

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    ts_d     = ts_q;
    valid_d  = valid_q;
    id_d     = id_q;
    tie_d    = tie_q;
    nospk_d  = nospk_q;
    counts_d = counts_q;
    cnt_clr  = 1'b0;
    cnt_en   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          cnt_clr = 1'b1;
          len_d   = window_len;
          ts_d    = '0;
          state_d = ST_COUNT;
        end
      end
      ST_COUNT: begin
        if (pulse) begin
          cnt_en = 1'b1;
          ts_d   = ts_q + CNT_W'(1);
          // len 0 wraps to all-ones here, giving a 2^CNT_W window.
          if (ts_q == len_q - CNT_W'(1)) state_d = ST_DECIDE;
        end
      end
      ST_DECIDE: begin
        id_d     = best_id;
        tie_d    = best_tie;
        nospk_d  = all_zero;
        counts_d = cnt_flat;
        valid_d  = 1'b1;
        state_d  = ST_HOLD;
      end
      ST_HOLD: begin
        if (class_ready) begin
          valid_d = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      len_q    <= '0;
      ts_q     <= '0;
      valid_q  <= 1'b0;
      id_q     <= '0;
      tie_q    <= 1'b0;
      nospk_q  <= 1'b0;
      counts_q <= '0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      ts_q     <= ts_d;
      valid_q  <= valid_d;
      id_q     <= id_d;
      tie_q    <= tie_d;
      nospk_q  <= nospk_d;
      counts_q <= counts_d;
    end
  end

  assign busy        = (state_q == ST_COUNT) || (state_q == ST_DECIDE);
  assign class_valid = valid_q;
  assign class_id    = id_q;
  assign class_tie   = tie_q;
  assign no_spike    = nospk_q;
  assign counts      = counts_q;

endmodule

// File: tb/tb_spike_count_classifier.sv
// Self-checking bench for spike_count_classifier (NUM_OUT=2, CNT_W=8).
module tb_spike_count_classifier;

  logic        clk = 1'b0;
  logic        reset;
  logic        pulse;
  logic [1:0]  spk_in;
  logic        start;
  logic [7:0]  window_len;
  logic        busy;
  logic        class_valid;
  logic        class_ready;
  logic [0:0]  class_id;
  logic        class_tie;
  logic        no_spike;
  logic [15:0] counts;

  spike_count_classifier #(.NUM_OUT(2), .CNT_W(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .pulse       (pulse),
    .spk_in      (spk_in),
    .start       (start),
    .window_len  (window_len),
    .busy        (busy),
    .class_valid (class_valid),
    .class_ready (class_ready),
    .class_id    (class_id),
    .class_tie   (class_tie),
    .no_spike    (no_spike),
    .counts      (counts)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         len;
    int         n_a;
    logic [1:0] pat_a;
    logic [1:0] pat_b;
    logic [7:0] c0;
    logic [7:0] c1;
    logic       id;
    logic       tie;
    logic       ns;
  } vec_t;

  vec_t vecs[7];
  vec_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic run_window(input vec_t v, input bit ack);
    int   n;
    int   lat;
    vec_t e;
    n = (v.len == 0) ? 256 : v.len;
    @(negedge clk);
    start = 1'b1;
    window_len = 8'(v.len);
    exp_q.push_back(v);
    @(negedge clk);
    start = 1'b0;
    window_len = 8'($urandom);
    chk("busy_in_count", 32'(busy), 32'd1);
    for (int p = 0; p < n; p++) begin
      pulse  = 1'b1;
      spk_in = (p < v.n_a) ? v.pat_a : v.pat_b;
      @(negedge clk);
      pulse  = 1'b0;
      spk_in = 2'($urandom);
      if (p != n - 1) @(negedge clk);
    end
    chk("decide_state", 32'({busy, class_valid}), 32'b10);
    lat = 0;
    while (!class_valid && lat < 4) begin
      @(negedge clk);
      lat++;
    end
    chk("valid_latency", 32'(lat), 32'd1);
    if (exp_q.size() == 0) begin
      chk("scoreboard_nonempty", 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      chk("counts", 32'(counts), 32'({e.c1, e.c0}));
      chk("class_id", 32'(class_id), 32'(e.id));
      chk("class_tie", 32'(class_tie), 32'(e.tie));
      chk("no_spike", 32'(no_spike), 32'(e.ns));
      chk("busy_in_hold", 32'(busy), 32'd0);
      if (ack) begin
        class_ready = 1'b1;
        @(negedge clk);
        class_ready = 1'b0;
        chk("ack_to_idle", 32'({class_valid, busy}), 32'b00);
        chk("counts_kept_idle", 32'(counts), 32'({e.c1, e.c0}));
      end
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t hv;
    vec_t rv;
    vecs[0] = '{len: 10, n_a: 7,  pat_a: 2'b01, pat_b: 2'b10, c0: 8'd7, c1: 8'd3,   id: 1'b0, tie: 1'b0, ns: 1'b0};
    vecs[1] = '{len: 4,  n_a: 4,  pat_a: 2'b11, pat_b: 2'b11, c0: 8'd4, c1: 8'd4,   id: 1'b0, tie: 1'b1, ns: 1'b0};
    vecs[2] = '{len: 5,  n_a: 5,  pat_a: 2'b00, pat_b: 2'b00, c0: 8'd0, c1: 8'd0,   id: 1'b0, tie: 1'b1, ns: 1'b1};
    vecs[3] = '{len: 0,  n_a: 256,pat_a: 2'b10, pat_b: 2'b10, c0: 8'd0, c1: 8'd255, id: 1'b1, tie: 1'b0, ns: 1'b0};
    vecs[4] = '{len: 1,  n_a: 1,  pat_a: 2'b01, pat_b: 2'b01, c0: 8'd1, c1: 8'd0,   id: 1'b0, tie: 1'b0, ns: 1'b0};
    vecs[5] = '{len: 6,  n_a: 2,  pat_a: 2'b11, pat_b: 2'b10, c0: 8'd2, c1: 8'd6,   id: 1'b1, tie: 1'b0, ns: 1'b0};
    vecs[6] = '{len: 5,  n_a: 2,  pat_a: 2'b01, pat_b: 2'b10, c0: 8'd2, c1: 8'd3,   id: 1'b1, tie: 1'b0, ns: 1'b0};

    reset = 1'b1;
    pulse = 1'b0;
    spk_in = 2'b00;
    start = 1'b0;
    window_len = 8'd0;
    class_ready = 1'b0;
    #1;
    chk("reset_outputs", 32'({busy, class_valid, class_id, class_tie, no_spike, counts}), 32'd0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    for (int i = 0; i < 7; i++) run_window(vecs[i], 1'b1);

    // Result must stay frozen in HOLD while start/pulse/spk_in toggle.
    hv = '{len: 4, n_a: 4, pat_a: 2'b11, pat_b: 2'b11, c0: 8'd4, c1: 8'd4, id: 1'b0, tie: 1'b1, ns: 1'b0};
    run_window(hv, 1'b0);
    for (int c = 0; c < 20; c++) begin
      start = (c == 5);
      window_len = 8'd3;
      pulse = 1'($urandom);
      spk_in = 2'($urandom);
      class_ready = 1'b0;
      @(negedge clk);
      chk("hold_stable", 32'({class_valid, busy, counts, class_id, class_tie, no_spike}),
          32'({1'b1, 1'b0, 8'd4, 8'd4, 1'b0, 1'b1, 1'b0}));
    end
    pulse = 1'b0;
    start = 1'b1;
    class_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    class_ready = 1'b0;
    chk("ack_with_start", 32'({class_valid, busy}), 32'b00);
    @(negedge clk);
    chk("start_ignored_at_ack", 32'(busy), 32'd0);

    // Abort a window after 3 of 8 pulses.
    rv = '{len: 8, n_a: 8, pat_a: 2'b11, pat_b: 2'b11, c0: 8'd8, c1: 8'd8, id: 1'b0, tie: 1'b1, ns: 1'b0};
    start = 1'b1;
    window_len = 8'd8;
    exp_q.push_back(rv);
    @(negedge clk);
    start = 1'b0;
    for (int p = 0; p < 3; p++) begin
      pulse = 1'b1;
      spk_in = 2'b11;
      @(negedge clk);
      pulse = 1'b0;
      @(negedge clk);
    end
    chk("busy_before_abort", 32'(busy), 32'd1);
    #2 reset = 1'b1;
    void'(exp_q.pop_back());
    #1;
    chk("abort_outputs", 32'({busy, class_valid, class_id, class_tie, no_spike, counts}), 32'd0);
    repeat (12) begin
      pulse = 1'($urandom);
      spk_in = 2'b11;
      @(negedge clk);
    end
    pulse = 1'b0;
    chk("no_valid_after_abort", 32'(class_valid), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    run_window(vecs[0], 1'b1);

    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
